// File: rtl/shake_selftest_seq_if.sv
// Core-side bus of the SHAKE256 self-test sequencer.
// Carries the launch pulse and vector index to the core, and the completion pulse back.
// Also carries the core digest and the expected digest from the ROM.
interface shake_selftest_seq_if #(
   parameter int NUM_VEC  = 4,
   parameter int DIGEST_W = 256
);
   localparam int IDX_W = $clog2(NUM_VEC);

   logic                core_start;
   logic [IDX_W-1:0]    core_idx;
   logic                core_done;
   logic [DIGEST_W-1:0] core_digest;
   logic [DIGEST_W-1:0] exp_digest;

   // sequencer side
   modport master (
      output core_start,
      output core_idx,
      input  core_done,
      input  core_digest,
      input  exp_digest
   );

   // hash core + expected-digest ROM side
   modport slave (
      input  core_start,
      input  core_idx,
      output core_done,
      output core_digest,
      output exp_digest
   );
endinterface

// File: rtl/shake_selftest_seq.sv
// Known-answer self-test sequencer for the SHAKE256 core: one vector or all vectors per run.
// core_start rises 2 cycles after the start edge is seen; 3 cycles from core_done to the next core_start.
// A start is accepted only in IDLE, and core_done is honoured only while waiting. A watchdog bounds every wait.
module shake_selftest_seq #(
   parameter  int NUM_VEC     = 4,
   parameter  int DIGEST_W    = 256,
   parameter  int TIMEOUT_CYC = 100000,
   localparam int IDX_W       = $clog2(NUM_VEC),
   localparam int CNT_W       = IDX_W + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sw_start,
   input  logic                 mode_all,
   input  logic [IDX_W-1:0]     vec_sel,
   shake_selftest_seq_if.master core,
   output logic                 busy,
   output logic                 run_done,
   output logic [CNT_W-1:0]     pass_count,
   output logic [CNT_W-1:0]     fail_count,
   output logic [NUM_VEC-1:0]   fail_mask,
   output logic                 timeout_flag,
   output logic                 led_idle,
   output logic                 led_processing,
   output logic                 led_correct,
   output logic                 led_incorrect
);
   localparam int               WD_W     = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
   localparam logic [IDX_W:0]   NV_EXT   = (IDX_W + 1)'(NUM_VEC);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CHECK, DONE} state_t;

   state_t              state;
   logic                sw_start_q;
   logic                mode_q;      // mode_all captured at start
   logic                idx_ok;      // core_idx names a real vector (mask bit exists)
   logic                match;       // verdict of the vector just waited on
   logic [WD_W-1:0]     wd;          // WAIT cycles already spent on this vector
   logic                start_edge;
   logic                sel_ok;
   logic [DIGEST_W-1:0] digest_diff;
   logic                digest_eq;

   assign start_edge     = sw_start & ~sw_start_q;
   assign sel_ok         = ({1'b0, vec_sel} < NV_EXT);
   assign digest_diff    = core.core_digest ^ core.exp_digest;
   assign digest_eq      = ~|digest_diff;
   assign led_processing = busy;

   // Run sequencing, watchdog, result accumulation and LED verdict in one registered FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         sw_start_q      <= sw_start;   // a switch held through reset is not an edge
         mode_q          <= 1'b0;
         idx_ok          <= 1'b0;
         match           <= 1'b0;
         wd              <= '0;
         core.core_start <= 1'b0;
         core.core_idx   <= '0;
         busy            <= 1'b0;
         run_done        <= 1'b0;
         pass_count      <= '0;
         fail_count      <= '0;
         fail_mask       <= '0;
         timeout_flag    <= 1'b0;
         led_idle        <= 1'b1;
         led_correct     <= 1'b0;
         led_incorrect   <= 1'b0;
      end else begin
         sw_start_q      <= sw_start;
         core.core_start <= 1'b0;
         run_done        <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  mode_q        <= mode_all;
                  core.core_idx <= mode_all ? '0 : vec_sel;
                  pass_count    <= '0;
                  fail_count    <= '0;
                  fail_mask     <= '0;
                  timeout_flag  <= 1'b0;
                  busy          <= 1'b1;
                  led_idle      <= 1'b0;
                  led_correct   <= 1'b0;
                  led_incorrect <= 1'b0;
                  if (!mode_all && !sel_ok) begin
                     // nonexistent vector: never launched, scored as a single failure
                     idx_ok <= 1'b0;
                     match  <= 1'b0;
                     state  <= CHECK;
                  end else begin
                     idx_ok <= 1'b1;
                     state  <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               core.core_start <= 1'b1;
               wd              <= '0;
               state           <= WAIT;
            end
            WAIT: begin
               // core_done is tested first so it wins over an expiring watchdog
               if (core.core_done) begin
                  match <= digest_eq;
                  state <= CHECK;
               end else if (wd == WD_LAST) begin
                  match        <= 1'b0;
                  timeout_flag <= 1'b1;
                  state        <= CHECK;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            CHECK: begin
               if (match) begin
                  pass_count <= pass_count + CNT_W'(1);
               end else begin
                  fail_count <= fail_count + CNT_W'(1);
                  if (idx_ok) fail_mask[core.core_idx] <= 1'b1;
               end
               if (mode_q && core.core_idx != LAST_IDX) begin
                  core.core_idx <= core.core_idx + IDX_W'(1);
                  state         <= LAUNCH;
               end else begin
                  run_done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               busy          <= 1'b0;
               led_idle      <= 1'b1;
               led_correct   <= (fail_count == '0);
               led_incorrect <= (fail_count != '0);
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
